branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
Parametrised branch target buffer with saturating-counter direction prediction for the five-stage RV32I pipeline.
- The IF stage looks up the current PC in the same cycle and receives a predicted next PC, so the PC mux no longer waits for EX/MEM branch resolution.
- The EX stage sends resolved branch/jump outcomes back to train the table.
- Generalises the fixed "PC+4 unless resolved branch" selection to a configurable-depth, configurable-counter-width predictor.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, 2..1024; IDX_W = log2(ENTRIES).
- XLEN, 32, PC and target width.
- CNT_W, 2, direction counter width, 1..4.

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  reset; asynchronous, active-low.
- lkp_pc_i  input  XLEN  IF-stage PC to predict.
- lkp_valid_i  input  1  lookup qualifier; counted only when the stats feature is built in.
- pred_hit_o  output  1  valid entry with matching tag.
- pred_taken_o  output  1  predicted taken.
- pred_next_pc_o  output  XLEN  predicted next PC.
- upd_valid_i  input  1  resolved control-flow instruction this cycle.
- upd_pc_i  input  XLEN  PC of the resolved instruction.
- upd_taken_i  input  1  actual outcome.
- upd_target_i  input  XLEN  actual target (used when taken).
- upd_mispredict_i  input  1  prediction was wrong; statistics only.
- inv_all_i  input  1  invalidate whole table (fence.i / context flush).
- stat_lookups_o  output  32  lookup count.
- stat_hits_o  output  32  hit count.
- stat_mispred_o  output  32  mispredict count.

Behaviour:
- Address split:
  - index = pc[IDX_W+1:2].
  - tag = pc[XLEN-1:IDX_W+2].
  - pc[1:0] is ignored.
- Each entry holds: valid, tag, target, counter[CNT_W-1:0].
- Lookup is combinational, with zero-cycle latency from lkp_pc_i:
  - hit = valid && tag match.
  - taken = hit && counter[CNT_W-1].
  - pred_next_pc_o = taken ? target : lkp_pc_i + 4, modulo 2^XLEN (PC+4 wrap-around is allowed).
  - The outputs are a function of lkp_pc_i whether or not lkp_valid_i is asserted.
- Update happens at the clock edge when upd_valid_i is high:
  - Tag hit, taken: counter saturates up to 2^CNT_W-1; target <= upd_target_i.
  - Tag hit, not taken: counter saturates down to 0; target unchanged.
  - Miss, taken: allocate (overwrite whatever is at the index): valid=1, tag, target, counter = 2^(CNT_W-1) (weakly taken).
  - Miss, not taken: no change.
- Write is visible on the next cycle. A same-cycle lookup of the entry being updated returns the pre-update contents.
- inv_all_i clears every valid bit at the next edge. It takes priority over a simultaneous update; that update is dropped.
- Reset, asynchronous and at any time including mid-update:
  - All valid bits = 0; tags and targets = 0; counters = 2^(CNT_W-1)-1 (weakly not taken); statistics = 0.
  - Output values follow from the cleared state: pred_hit_o = 0, pred_taken_o = 0, pred_next_pc_o = lkp_pc_i+4.
- CNT_W = 1 gives a last-outcome predictor: allocate value 1, reset value 0.
- The block contains no stall logic; the pipeline's hazard unit handles flush on mispredict.

Optional Feature:
- Macro: BRANCH_PREDICTOR_STATS_EN.
- Defined: three 32-bit counters, each saturating at 32'hFFFF_FFFF:
  - stat_lookups_o increments on each cycle with lkp_valid_i.
  - stat_hits_o increments on each cycle with lkp_valid_i && pred_hit_o.
  - stat_mispred_o increments on each cycle with upd_valid_i && upd_mispredict_i.
  - inv_all_i does not clear the counters; only reset does.
- Undefined: no counter registers are built; the three stat outputs are tied to 0.

Test Plan:
All scenarios use ENTRIES=16, CNT_W=2.
1. Release reset; lookup 0x100 -> hit=0, taken=0, next_pc=0x104.
2. Update pc 0x100, taken, target 0x080. Next cycle lookup 0x100 -> hit=1, taken=1, next_pc=0x080. In the update cycle itself, lookup 0x100 -> hit=0.
3. Two not-taken updates at 0x100 -> counter goes 2 -> 1 -> 0; lookup gives hit=1, taken=0, next_pc=0x104. Five taken updates -> counter saturates at 3; one not-taken -> 2, still taken.
4. Aliasing: entry for 0x100 exists; taken update at 0x140 (same index 0, different tag) with target 0x200. Lookup 0x100 -> hit=0; lookup 0x140 -> next_pc=0x200.
5. inv_all_i and a taken update at 0x300 in the same cycle -> afterwards lookups at 0x100 and 0x300 both miss. Assert rst_ni low mid-cycle during an update -> the table clears immediately and the update is lost.
6. With BRANCH_PREDICTOR_STATS_EN defined: 10 valid lookups (4 hits) and 3 mispredict updates -> stat_lookups_o=10, stat_hits_o=4, stat_mispred_o=3. Without the macro, all three read 0.

Source files
------------

// File: rtl/branch_predictor.sv
// Branch target buffer with saturating direction counters for the RV32I IF stage.
// Optional lookup/hit/mispredict statistics are built when BRANCH_PREDICTOR_STATS_EN is defined.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int XLEN    = 32,
  parameter int CNT_W   = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [XLEN-1:0] lkp_pc_i,
  input  logic            lkp_valid_i,
  output logic            pred_hit_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_next_pc_o,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_target_i,
  input  logic            upd_mispredict_i,
  input  logic            inv_all_i,
  output logic [31:0]     stat_lookups_o,
  output logic [31:0]     stat_hits_o,
  output logic [31:0]     stat_mispred_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - CNT_W'(1);

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic [CNT_W-1:0] cnt_q    [ENTRIES];

  logic [IDX_W-1:0] lkp_idx;
  logic [TAG_W-1:0] lkp_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic [CNT_W-1:0] upd_cnt;
  logic [CNT_W-1:0] cnt_d;
  logic             upd_we;

  // Lookup path: purely combinational so the PC mux sees the prediction in the same cycle.
  assign lkp_idx        = lkp_pc_i[IDX_W+1:2];
  assign lkp_tag        = lkp_pc_i[XLEN-1:IDX_W+2];
  assign pred_hit_o     = valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);
  assign pred_taken_o   = pred_hit_o && cnt_q[lkp_idx][CNT_W-1];
  assign pred_next_pc_o = pred_taken_o ? target_q[lkp_idx] : lkp_pc_i + XLEN'(4);

  assign upd_idx = upd_pc_i[IDX_W+1:2];
  assign upd_tag = upd_pc_i[XLEN-1:IDX_W+2];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_cnt = cnt_q[upd_idx];

  always_comb begin
    cnt_d = upd_cnt;
    if (upd_taken_i) begin
      if (!upd_hit)
        cnt_d = CNT_WT;
      else if (upd_cnt != CNT_MAX)
        cnt_d = upd_cnt + CNT_W'(1);
    end else if (upd_cnt != '0) begin
      cnt_d = upd_cnt - CNT_W'(1);
    end
  end

  // A not-taken miss never allocates; invalidation drops any concurrent update.
  assign upd_we = upd_valid_i && !inv_all_i && (upd_hit || upd_taken_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_WNT;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (inv_all_i) begin
          valid_q[i] <= 1'b0;
        end else if (upd_we && (upd_idx == IDX_W'(i))) begin
          valid_q[i] <= 1'b1;
          tag_q[i]   <= upd_tag;
          cnt_q[i]   <= cnt_d;
          if (upd_taken_i)
            target_q[i] <= upd_target_i;
        end
      end
    end
  end

  logic unused_pc_bits;
  assign unused_pc_bits = &{1'b0, upd_pc_i[1:0]};

`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] lookups_q;
  logic [31:0] hits_q;
  logic [31:0] mispred_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lookups_q <= '0;
      hits_q    <= '0;
      mispred_q <= '0;
    end else begin
      if (lkp_valid_i && (lookups_q != 32'hFFFF_FFFF))
        lookups_q <= lookups_q + 32'd1;
      if (lkp_valid_i && pred_hit_o && (hits_q != 32'hFFFF_FFFF))
        hits_q <= hits_q + 32'd1;
      if (upd_valid_i && upd_mispredict_i && (mispred_q != 32'hFFFF_FFFF))
        mispred_q <= mispred_q + 32'd1;
    end
  end

  assign stat_lookups_o = lookups_q;
  assign stat_hits_o    = hits_q;
  assign stat_mispred_o = mispred_q;
`else
  logic unused_stat_inputs;
  assign unused_stat_inputs = &{1'b0, lkp_valid_i, upd_mispredict_i};

  assign stat_lookups_o = '0;
  assign stat_hits_o    = '0;
  assign stat_mispred_o = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor (ENTRIES=16, CNT_W=2).
module tb_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic [31:0] lkp_pc;
  logic        lkp_valid;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_next_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic        inv_all;
  logic [31:0] stat_lookups;
  logic [31:0] stat_hits;
  logic [31:0] stat_mispred;

  int vec_cnt = 0;
  int err_cnt = 0;

  branch_predictor #(.ENTRIES(16), .XLEN(32), .CNT_W(2)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .lkp_pc_i         (lkp_pc),
    .lkp_valid_i      (lkp_valid),
    .pred_hit_o       (pred_hit),
    .pred_taken_o     (pred_taken),
    .pred_next_pc_o   (pred_next_pc),
    .upd_valid_i      (upd_valid),
    .upd_pc_i         (upd_pc),
    .upd_taken_i      (upd_taken),
    .upd_target_i     (upd_target),
    .upd_mispredict_i (upd_mispredict),
    .inv_all_i        (inv_all),
    .stat_lookups_o   (stat_lookups),
    .stat_hits_o      (stat_hits),
    .stat_mispred_o   (stat_mispred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // Drive one update across a single rising edge; returns at the following falling edge.
  task automatic do_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    @(negedge clk);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_taken  = tk;
    upd_target = tg;
    @(negedge clk);
    upd_valid  = 1'b0;
  endtask

  task automatic look(input string nm, input logic [31:0] pc, input logic eh,
                      input logic et, input logic [31:0] enp);
    lkp_pc = pc;
    #1;
    check_vec({nm, ".hit"},   32'(pred_hit),   32'(eh));
    check_vec({nm, ".taken"}, 32'(pred_taken), 32'(et));
    check_vec({nm, ".next"},  pred_next_pc,    enp);
  endtask

  initial begin
    logic [31:0] exp_lk, exp_ht, exp_mp;
    rst_n = 1'b0; lkp_pc = '0; lkp_valid = 1'b0; upd_valid = 1'b0; upd_pc = '0;
    upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0; inv_all = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    look("rst_lkp100", 32'h100, 1'b0, 1'b0, 32'h104);
    check_vec("rst_stat_lk", stat_lookups, 32'd0);
    check_vec("rst_stat_ht", stat_hits, 32'd0);
    check_vec("rst_stat_mp", stat_mispred, 32'd0);
    look("wrap_pc4", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

    // Allocate; same-cycle lookup sees pre-update contents
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h080;
    look("same_cyc", 32'h100, 1'b0, 1'b0, 32'h104);
    @(negedge clk);
    upd_valid = 1'b0;
    look("alloc", 32'h100, 1'b1, 1'b1, 32'h080);

    // Counter walk: 2 -> 1 -> 0 -> 0 -> 1 -> ... -> 3 -> 2 -> 1
    do_upd(32'h100, 1'b0, 32'h0);
    look("cnt1", 32'h100, 1'b1, 1'b0, 32'h104);
    do_upd(32'h100, 1'b0, 32'h0);
    look("cnt0", 32'h100, 1'b1, 1'b0, 32'h104);
    do_upd(32'h100, 1'b0, 32'h0);
    do_upd(32'h100, 1'b1, 32'h080);
    look("sat_dn", 32'h100, 1'b1, 1'b0, 32'h104);
    for (int i = 0; i < 4; i++) do_upd(32'h100, 1'b1, 32'h080);
    do_upd(32'h100, 1'b0, 32'h0);
    look("sat_up_nt", 32'h100, 1'b1, 1'b1, 32'h080);
    do_upd(32'h100, 1'b0, 32'h0);
    look("cnt_back1", 32'h100, 1'b1, 1'b0, 32'h104);

    // Aliasing at index 0, then target refresh on a taken hit
    do_upd(32'h140, 1'b1, 32'h200);
    look("alias_old", 32'h100, 1'b0, 1'b0, 32'h104);
    look("alias_new", 32'h140, 1'b1, 1'b1, 32'h200);
    do_upd(32'h140, 1'b1, 32'h240);
    look("tgt_upd", 32'h140, 1'b1, 1'b1, 32'h240);

    // Invalidate wins over a simultaneous update
    do_upd(32'h104, 1'b1, 32'h400);
    look("alloc104", 32'h104, 1'b1, 1'b1, 32'h400);
    @(negedge clk);
    inv_all = 1'b1; upd_valid = 1'b1; upd_pc = 32'h300; upd_taken = 1'b1; upd_target = 32'h500;
    @(negedge clk);
    inv_all = 1'b0; upd_valid = 1'b0;
    look("inv_104", 32'h104, 1'b0, 1'b0, 32'h108);
    look("inv_300", 32'h300, 1'b0, 1'b0, 32'h304);
    look("inv_140", 32'h140, 1'b0, 1'b0, 32'h144);

    // Asynchronous reset in the middle of an update
    do_upd(32'h108, 1'b1, 32'h600);
    look("alloc108", 32'h108, 1'b1, 1'b1, 32'h600);
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h080;
    #2 rst_n = 1'b0;
    look("arst_108", 32'h108, 1'b0, 1'b0, 32'h10C);
    @(negedge clk);
    upd_valid = 1'b0;
    rst_n = 1'b1;
    look("arst_lost", 32'h100, 1'b0, 1'b0, 32'h104);

    // Statistics: 10 valid lookups (4 hits), 3 mispredicts
    do_upd(32'h100, 1'b1, 32'h080);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lkp_valid = 1'b1;
      lkp_pc = (i < 4) ? 32'h100 : 32'h500;
    end
    @(negedge clk);
    lkp_valid = 1'b0;
    upd_valid = 1'b1; upd_pc = 32'h600; upd_taken = 1'b0; upd_mispredict = 1'b1;
    repeat (3) @(negedge clk);
    upd_valid = 1'b0; upd_mispredict = 1'b0;
    inv_all = 1'b1;
    @(negedge clk);
    inv_all = 1'b0;
    #1;
`ifdef BRANCH_PREDICTOR_STATS_EN
    exp_lk = 32'd10; exp_ht = 32'd4; exp_mp = 32'd3;
`else
    exp_lk = 32'd0; exp_ht = 32'd0; exp_mp = 32'd0;
`endif
    check_vec("stat_lookups", stat_lookups, exp_lk);
    check_vec("stat_hits", stat_hits, exp_ht);
    check_vec("stat_mispred", stat_mispred, exp_mp);
    look("stat_noalloc", 32'h600, 1'b0, 1'b0, 32'h604);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
